// File: rtl/sram_port_arbiter_if.sv
// One requester-side transaction port of the SRAM arbiter: a request with its
// fields, held until a single-cycle ack that also qualifies the read data.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
);
    logic                  req;
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, wmask, addr, wdata, input ack, rdata);
    modport slave  (input req, we, wmask, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one SRAM read/write port between
// requester ports A and B; every SRAM pin and ack/rdata output is registered.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_port_arbiter_if.slave    a,
    sram_port_arbiter_if.slave    b,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic [1:0] {IDLE, CMD, RWAIT, RESP} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t state;
    logic   rr;
    logic   gnt;
    logic   lat_we;

    logic                  any_req;
    logic                  take_b;
    logic                  sel_we;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Grant selection: a lone requester wins, otherwise rr breaks the tie.
    always_comb begin
        any_req   = a.req | b.req;
        take_b    = b.req & (~a.req | (rr == PORT_B));
        sel_we    = take_b ? b.we    : a.we;
        sel_wmask = take_b ? b.wmask : a.wmask;
        sel_addr  = take_b ? b.addr  : a.addr;
        sel_wdata = take_b ? b.wdata : a.wdata;
    end

    // The SRAM pin registers double as the latched command, so CMD drives them directly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rr      <= PORT_A;
            gnt     <= PORT_A;
            lat_we  <= 1'b0;
            csb0    <= 1'b1;
            web0    <= 1'b1;
            wmask0  <= '0;
            addr0   <= '0;
            din0    <= '0;
            a.ack   <= 1'b0;
            b.ack   <= 1'b0;
            a.rdata <= '0;
            b.rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt    <= take_b;
                        lat_we <= sel_we;
                        addr0  <= sel_addr;
                        state  <= CMD;
                        if (!sel_we) begin
                            csb0 <= 1'b0;
                        end else if (sel_wmask != '0) begin
                            csb0   <= 1'b0;
                            web0   <= 1'b0;
                            wmask0 <= sel_wmask;
                            din0   <= sel_wdata;
                        end
                    end
                end
                CMD: begin
                    csb0   <= 1'b1;
                    web0   <= 1'b1;
                    wmask0 <= '0;
                    if (lat_we) begin
                        state <= RESP;
                        if (gnt == PORT_B) b.ack <= 1'b1;
                        else               a.ack <= 1'b1;
                    end else begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    state <= RESP;
                    if (gnt == PORT_B) begin
                        b.rdata <= dout0;
                        b.ack   <= 1'b1;
                    end else begin
                        a.rdata <= dout0;
                        a.ack   <= 1'b1;
                    end
                end
                RESP: begin
                    a.ack <= 1'b0;
                    b.ack <= 1'b0;
                    rr    <= ~gnt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// 512x32 byte-masked SRAM model attached to port 0.
module tb_sram_port_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          csb0;
    logic          web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
    logic [DW-1:0] mem [0:511];

    int tests = 0;
    int fails = 0;

    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) a_if ();
    sram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) b_if ();

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .a      (a_if),
        .b      (b_if),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0)
    );

    always #5 clk = ~clk;

    // SRAM macro model: synchronous access, read data valid after the access edge.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++)
                    if (wmask0[i]) mem[addr0][8*i +: 8] <= din0[8*i +: 8];
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic drive(input bit chain, input bit pb, input logic we, input logic [3:0] m,
                         input logic [8:0] ad, input logic [31:0] d);
        if (!chain) @(negedge clk);
        if (pb) begin
            b_if.req = 1'b1; b_if.we = we; b_if.wmask = m; b_if.addr = ad; b_if.wdata = d;
        end else begin
            a_if.req = 1'b1; a_if.we = we; a_if.wmask = m; a_if.addr = ad; a_if.wdata = d;
        end
    endtask

    task automatic release_port(input bit pb);
        if (pb) b_if.req = 1'b0;
        else    a_if.req = 1'b0;
    endtask

    // Counts negedges until this port's ack; cyc = -1 when the budget runs out.
    task automatic wait_ack(input bit pb, input int maxc, output int cyc, output logic [31:0] rd,
                            output bit csb_low, output bit other);
        bit done = 1'b0;
        cyc = 0; rd = '0; csb_low = 1'b0; other = 1'b0;
        while (!done && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (csb0 === 1'b0) csb_low = 1'b1;
            if ((pb ? a_if.ack : b_if.ack) === 1'b1) other = 1'b1;
            if ((pb ? b_if.ack : a_if.ack) === 1'b1) begin
                done = 1'b1;
                rd = pb ? b_if.rdata : a_if.rdata;
            end
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset_values;
        @(negedge clk);
        tests++; if (csb0 !== 1'b1) begin fails++; $display("FAIL rst_csb0: got %b want 1", csb0); end
        tests++; if (web0 !== 1'b1) begin fails++; $display("FAIL rst_web0: got %b want 1", web0); end
        tests++; if (wmask0 !== 4'h0) begin fails++; $display("FAIL rst_wmask0: got %h want 0", wmask0); end
        tests++; if (addr0 !== 9'h0 || din0 !== 32'h0) begin
            fails++; $display("FAIL rst_addr_din: got %h/%h want 0/0", addr0, din0); end
        tests++; if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin
            fails++; $display("FAIL rst_ack: got %b%b want 00", a_if.ack, b_if.ack); end
        tests++; if (a_if.rdata !== 32'h0 || b_if.rdata !== 32'h0) begin
            fails++; $display("FAIL rst_rdata: got %h/%h want 0/0", a_if.rdata, b_if.rdata); end
    endtask

    task automatic test_single_a;
        int cyc; logic [31:0] rd; bit cl; bit ot;
        drive(1'b0, 1'b0, 1'b1, 4'hF, 9'h1A5, 32'hDEADBEEF);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        release_port(1'b0);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL a_write_latency: got %0d want 2", cyc); end
        tests++; if (cl !== 1'b1) begin fails++; $display("FAIL a_write_csb: got %b want 1", cl); end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 9'h1A5, 32'h0);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        release_port(1'b0);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL a_read_latency: got %0d want 3", cyc); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL a_read_data: got %h want deadbeef", rd); end
        tests++; if (ot !== 1'b0) begin fails++; $display("FAIL a_stray_b_ack: got %b want 0", ot); end
    endtask

    task automatic test_byte_mask_b;
        int cyc; logic [31:0] rd; bit cl; bit ot;
        drive(1'b0, 1'b1, 1'b1, 4'hF, 9'h000, 32'h11223344);
        wait_ack(1'b1, 20, cyc, rd, cl, ot);
        release_port(1'b1);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL b_write_latency: got %0d want 2", cyc); end
        drive(1'b0, 1'b1, 1'b1, 4'b0101, 9'h000, 32'hAABBCCDD);
        wait_ack(1'b1, 20, cyc, rd, cl, ot);
        release_port(1'b1);
        drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h000, 32'h0);
        wait_ack(1'b1, 20, cyc, rd, cl, ot);
        release_port(1'b1);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL b_read_latency: got %0d want 3", cyc); end
        tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL b_masked_data: got %h want 11bb33dd", rd); end
        tests++; if (ot !== 1'b0) begin fails++; $display("FAIL b_stray_a_ack: got %b want 0", ot); end
        tests++; if (a_if.rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL a_rdata_hold: got %h want deadbeef", a_if.rdata); end
    endtask

    task automatic test_zero_mask;
        int cyc; logic [31:0] rd; bit cl; bit ot;
        drive(1'b0, 1'b1, 1'b1, 4'h0, 9'h000, 32'hFFFFFFFF);
        wait_ack(1'b1, 20, cyc, rd, cl, ot);
        release_port(1'b1);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL zmask_latency: got %0d want 2", cyc); end
        tests++; if (cl !== 1'b0) begin fails++; $display("FAIL zmask_csb: csb0 low seen %b want 0", cl); end
        tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL zmask_rdata_hold: got %h want 11bb33dd", rd); end
        drive(1'b0, 1'b1, 1'b0, 4'h0, 9'h000, 32'h0);
        wait_ack(1'b1, 20, cyc, rd, cl, ot);
        release_port(1'b1);
        tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL zmask_mem: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_back_to_back_boundary;
        int cyc; logic [31:0] rd; bit cl; bit ot;
        drive(1'b0, 1'b0, 1'b1, 4'hF, 9'h1FF, 32'hCAFEF00D);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        tests++; if (cyc !== 2) begin fails++; $display("FAIL b2b_w1ff_latency: got %0d want 2", cyc); end
        drive(1'b1, 1'b0, 1'b1, 4'hF, 9'h000, 32'h0BADC0DE);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL b2b_w000_latency: got %0d want 3", cyc); end
        drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h1FF, 32'h0);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        tests++; if (cyc !== 4) begin fails++; $display("FAIL b2b_r1ff_latency: got %0d want 4", cyc); end
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL wrap_1ff_data: got %h want cafef00d", rd); end
        drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
        wait_ack(1'b0, 20, cyc, rd, cl, ot);
        release_port(1'b0);
        tests++; if (cyc !== 4) begin fails++; $display("FAIL b2b_r000_latency: got %0d want 4", cyc); end
        tests++; if (rd !== 32'h0BADC0DE) begin fails++; $display("FAIL wrap_000_data: got %h want 0badc0de", rd); end
    endtask

    task automatic test_reset_midcmd;
        bit stray = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 9'h1A5, 32'h0);
        @(posedge clk); #2;
        tests++; if (csb0 !== 1'b0) begin fails++; $display("FAIL midcmd_csb_low: got %b want 0", csb0); end
        resetn = 1'b0;
        a_if.req = 1'b0;
        #1;
        tests++; if (csb0 !== 1'b1 || web0 !== 1'b1) begin
            fails++; $display("FAIL midrst_ctrl: csb0/web0 got %b%b want 11", csb0, web0); end
        tests++; if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin
            fails++; $display("FAIL midrst_ack: got %b%b want 00", a_if.ack, b_if.ack); end
        tests++; if (a_if.rdata !== 32'h0 || b_if.rdata !== 32'h0) begin
            fails++; $display("FAIL midrst_rdata: got %h/%h want 0/0", a_if.rdata, b_if.rdata); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0 || csb0 !== 1'b1) stray = 1'b1;
        end
        tests++; if (stray !== 1'b0) begin fails++; $display("FAIL midrst_aborted: activity %b want 0", stray); end
    endtask

    task automatic test_contention;
        int cyc = 0; int nack = 0; int last = 0; int na = 0; int nb = 0;
        bit both = 1'b0; bit stray = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'h0, 9'h1A5, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
        while (nack < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (a_if.ack === 1'b1 && b_if.ack === 1'b1) both = 1'b1;
            if (a_if.ack === 1'b1 || b_if.ack === 1'b1) begin
                tests++;
                if (b_if.ack !== nack[0]) begin
                    fails++; $display("FAIL rr_order_%0d: b_ack got %b want %b", nack, b_if.ack, nack[0]);
                end
                tests++;
                if ((b_if.ack ? b_if.rdata : a_if.rdata) !== (nack[0] ? 32'hCAFEF00D : 32'hDEADBEEF)) begin
                    fails++; $display("FAIL rr_data_%0d: got %h/%h", nack, a_if.rdata, b_if.rdata);
                end
                tests++;
                if ((cyc - last) !== ((nack == 0) ? 3 : 4)) begin
                    fails++; $display("FAIL rr_spacing_%0d: got %0d want %0d", nack, cyc - last, (nack == 0) ? 3 : 4);
                end
                if (a_if.ack === 1'b1) na++;
                if (b_if.ack === 1'b1) nb++;
                last = cyc;
                nack++;
            end
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        tests++; if (nack !== 8) begin fails++; $display("FAIL rr_timeout: got %0d acks want 8", nack); end
        tests++; if (na !== 4 || nb !== 4) begin fails++; $display("FAIL rr_counts: got %0d/%0d want 4/4", na, nb); end
        tests++; if (both !== 1'b0) begin fails++; $display("FAIL rr_dual_ack: got %b want 0", both); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) stray = 1'b1;
        end
        tests++; if (stray !== 1'b0) begin fails++; $display("FAIL rr_idle_ack: got %b want 0", stray); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.wmask = '0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.wmask = '0; b_if.addr = '0; b_if.wdata = '0;
        repeat (2) @(negedge clk);
        test_reset_values();
        resetn = 1'b1;
        test_single_a();
        test_byte_mask_b();
        test_zero_mask();
        test_back_to_back_boundary();
        test_reset_midcmd();
        test_contention();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
